// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-wide slice of the carry chain
// per stage, carry registered between stages, valid/ready with a global stall.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  // The whole pipeline moves or freezes together; bubbles are never collapsed.
  logic adv_s;
  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Stage k only carries the operand bits it and later stages still need.
    localparam int HI = WIDTH - k * CHUNK;

    logic                   v_in_s;
    logic                   c_in_s;
    logic [HI-1:0]          a_hi_s;
    logic [HI-1:0]          b_hi_s;
    logic [CHUNK:0]         part_s;
    logic [(k+1)*CHUNK-1:0] sum_next_s;

    logic                   v_r;
    logic                   c_r;
    logic [(k+1)*CHUNK-1:0] sum_r;

    if (k == 0) begin : g_first
      assign v_in_s     = in_valid;
      assign c_in_s     = sub;
      assign a_hi_s     = a;
      assign b_hi_s     = sub ? ~b : b;
      assign sum_next_s = part_s[CHUNK-1:0];
    end else begin : g_next
      assign v_in_s     = g_stage[k-1].v_r;
      assign c_in_s     = g_stage[k-1].c_r;
      assign a_hi_s     = g_stage[k-1].g_keep.a_r;
      assign b_hi_s     = g_stage[k-1].g_keep.b_r;
      assign sum_next_s = {part_s[CHUNK-1:0], g_stage[k-1].sum_r};
    end

    assign part_s = {1'b0, a_hi_s[CHUNK-1:0]} + {1'b0, b_hi_s[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, c_in_s};

    // Valid, partial sum and chunk carry for this stage.
    always_ff @(posedge clk) begin
      if (reset) begin
        v_r   <= 1'b0;
        c_r   <= 1'b0;
        sum_r <= {((k+1)*CHUNK){1'b0}};
      end else if (adv_s) begin
        v_r   <= v_in_s;
        c_r   <= part_s[CHUNK];
        sum_r <= sum_next_s;
      end
    end

    if (k < STAGES - 1) begin : g_keep
      logic [HI-CHUNK-1:0] a_r;
      logic [HI-CHUNK-1:0] b_r;

      // Upper operand chunks ride along untouched to the stages that add them.
      always_ff @(posedge clk) begin
        if (reset) begin
          a_r <= {(HI-CHUNK){1'b0}};
          b_r <= {(HI-CHUNK){1'b0}};
        end else if (adv_s) begin
          a_r <= a_hi_s[HI-1:CHUNK];
          b_r <= b_hi_s[HI-1:CHUNK];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_r;

      // Signed overflow: operands agree in sign but the result sign differs.
      always_ff @(posedge clk) begin
        if (reset) begin
          ovf_r <= 1'b0;
        end else if (adv_s) begin
          ovf_r <= (a_hi_s[HI-1] == b_hi_s[HI-1]) && (part_s[CHUNK-1] != a_hi_s[HI-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_r;
  assign sum       = g_stage[STAGES-1].sum_r;
  assign carry_out = g_stage[STAGES-1].c_r;
  assign overflow  = g_stage[STAGES-1].g_last.ovf_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: three instances (STAGES=4, 1, 32) share
// stimulus; sel routes handshakes to one of them at a time.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  int          sel = 0;
  int          total = 0;
  int          bad = 0;

  logic        iv [3];
  logic        ordy [3];
  logic        ir [3];
  logic        ov [3];
  logic        oc [3];
  logic        oo [3];
  logic [31:0] os [3];

  logic [31:0] va [16];
  logic [31:0] vb [16];
  logic        vs [16];
  logic [31:0] es [16];
  logic        ec [16];
  logic        eo [16];

  always #5 clk = ~clk;

  for (genvar x = 0; x < 3; x++) begin : g_route
    assign iv[x]   = in_valid && (sel == x);
    assign ordy[x] = (sel == x) ? out_ready : 1'b1;
  end

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(os[0]), .carry_out(oc[0]), .overflow(oo[0]));

  pipelined_adder #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(os[1]), .carry_out(oc[1]), .overflow(oo[1]));

  pipelined_adder #(.WIDTH(32), .STAGES(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b), .sub(sub),
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(os[2]), .carry_out(oc[2]), .overflow(oo[2]));

  function automatic int lat_of(input int s);
    case (s)
      0:       return 4;
      1:       return 1;
      default: return 32;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      total++;
      if (ov[s] !== 1'b0 || os[s] !== 32'h0 || oc[s] !== 1'b0 || oo[s] !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs sel=%0d got v=%b s=%h c=%b o=%b want v=0 s=0 c=0 o=0",
                 s, ov[s], os[s], oc[s], oo[s]);
      end
      total++;
      if (ir[s] !== 1'b1) begin
        bad++;
        $display("FAIL reset_in_ready sel=%0d got %b want 1", s, ir[s]);
      end
    end
  endtask

  task automatic test_single(input logic [31:0] xa, input logic [31:0] xb, input logic xs,
                             input logic [31:0] xsum, input logic xc, input logic xo);
    int lat;
    lat = lat_of(sel);
    a = xa; b = xb; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int n = 1; n <= lat; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      total++;
      if (ov[sel] !== (n == lat)) begin
        bad++;
        $display("FAIL latency sel=%0d cycle=%0d got out_valid=%b want %b", sel, n, ov[sel], n == lat);
      end
    end
    total++;
    if (os[sel] !== xsum || oc[sel] !== xc || oo[sel] !== xo) begin
      bad++;
      $display("FAIL single_result sel=%0d got s=%h c=%b o=%b want s=%h c=%b o=%b",
               sel, os[sel], oc[sel], oo[sel], xsum, xc, xo);
    end
    @(posedge clk);
    #1;
    total++;
    if (ov[sel] !== 1'b0) begin
      bad++;
      $display("FAIL single_drain sel=%0d got out_valid=%b want 0", sel, ov[sel]);
    end
  endtask

  task automatic test_stream(input int n, input bit stall);
    int sent = 0;
    int rcv = 0;
    int stalled = 0;
    int cyc = 0;
    while (rcv < n && cyc < 300) begin
      if (sent < n) begin
        in_valid = 1'b1; a = va[sent]; b = vb[sent]; sub = vs[sent];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (stall && rcv == 2 && stalled < 3 && ov[sel] === 1'b1) ? 1'b0 : 1'b1;
      #1;
      if (out_ready == 1'b0) begin
        total++;
        if (ir[sel] !== 1'b0 || ov[sel] !== 1'b1 || os[sel] !== es[2]) begin
          bad++;
          $display("FAIL stall_hold sel=%0d got in_ready=%b v=%b s=%h want in_ready=0 v=1 s=%h",
                   sel, ir[sel], ov[sel], os[sel], es[2]);
        end
        stalled++;
      end else if (ov[sel] === 1'b1) begin
        total++;
        if (os[sel] !== es[rcv] || oc[sel] !== ec[rcv] || oo[sel] !== eo[rcv]) begin
          bad++;
          $display("FAIL stream_result sel=%0d beat=%0d got s=%h c=%b o=%b want s=%h c=%b o=%b",
                   sel, rcv, os[sel], oc[sel], oo[sel], es[rcv], ec[rcv], eo[rcv]);
        end
        rcv++;
      end
      if (in_valid && ir[sel]) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++;
    if (rcv != n) begin
      bad++;
      $display("FAIL stream_count sel=%0d got %0d results want %0d", sel, rcv, n);
    end
    if (stall) begin
      total++;
      if (stalled != 3) begin
        bad++;
        $display("FAIL stall_cycles sel=%0d got %0d want 3", sel, stalled);
      end
    end
  endtask

  task automatic test_corner();
    va[0] = 32'h7FFF_FFFF; vb[0] = 32'h1; vs[0] = 1'b0; es[0] = 32'h8000_0000; ec[0] = 1'b0; eo[0] = 1'b1;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'h1; vs[1] = 1'b0; es[1] = 32'h0000_0000; ec[1] = 1'b1; eo[1] = 1'b0;
    va[2] = 32'h0000_0000; vb[2] = 32'h1; vs[2] = 1'b1; es[2] = 32'hFFFF_FFFF; ec[2] = 1'b0; eo[2] = 1'b0;
    va[3] = 32'h0000_0005; vb[3] = 32'h3; vs[3] = 1'b1; es[3] = 32'h0000_0002; ec[3] = 1'b1; eo[3] = 1'b0;
    va[4] = 32'h8000_0000; vb[4] = 32'h1; vs[4] = 1'b1; es[4] = 32'h7FFF_FFFF; ec[4] = 1'b1; eo[4] = 1'b1;
    test_stream(5, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] sums [8];
    sums = '{32'h0, 32'h101, 32'h202, 32'h303, 32'h404, 32'h505, 32'h606, 32'h707};
    for (int i = 0; i < 8; i++) begin
      va[i] = i; vb[i] = 32'h100 * i; vs[i] = 1'b0;
      es[i] = sums[i]; ec[i] = 1'b0; eo[i] = 1'b0;
    end
    test_stream(8, 1'b1);
  endtask

  task automatic test_reset_flush();
    sel = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'h1000 + i; b = 32'h1; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      total++;
      if (ov[0] !== 1'b0) begin
        bad++;
        $display("FAIL flush_no_output cycle=%0d got out_valid=%b want 0", n, ov[0]);
      end
      @(posedge clk);
      #1;
    end
    test_single(32'h1234_0000, 32'h0000_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      test_single(32'h0040_0000, 32'h0000_0004, 1'b0, 32'h0040_0004, 1'b0, 1'b0);
      test_corner();
      test_back_to_back();
    end
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
